dds_playback_sequencer: RTL and testbench

//  Sequences two instruction ROM channels (A, B) for DDS playback. Replaces free-running address counters.

---
 rtl/dds_seq_pkg.sv | 20 ++
 rtl/dds_seq_addr_gen.sv | 31 +++
 rtl/dds_playback_sequencer.sv | 179 +++++++++++++++++
 tb/tb_dds_playback_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_seq_pkg.sv
// dds_seq_pkg: shared types and defaults for the DDS playback sequencer.
// Loop playback is compiled in with DDS_SEQ_LOOP_EN.
package dds_seq_pkg;

  localparam int ADDR_W_D   = 17;
  localparam int PERIOD_W_D = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic logic [PERIOD_W_D-1:0] period_eff(
    input logic [PERIOD_W_D-1:0] p
  );
    return (p == '0) ? PERIOD_W_D'(1) : p;
  endfunction

endpackage

// File: rtl/dds_seq_addr_gen.sv
// dds_seq_addr_gen: one ROM address channel walking a [start,end] window.
// Part of dds_playback_sequencer (DDS_SEQ_LOOP_EN enables loop playback).
module dds_seq_addr_gen
  import dds_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ADDR_W-1:0] win_start,
  input  logic [ADDR_W-1:0] win_end,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap
);

  assign wrap = (addr == win_end);

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_addr;
    end else if (step) begin
      addr <= wrap ? win_start : addr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/dds_playback_sequencer.sv
// dds_playback_sequencer: lock-step A/B ROM address sequencer for DDS playback.
// Define DDS_SEQ_LOOP_EN to add cfg_loops and multi-pass playback.
module dds_playback_sequencer
  import dds_seq_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_D,
  parameter int PERIOD_W = PERIOD_W_D,
  parameter int DELAY_W  = 32,
  parameter int LOOP_W   = 8,
  parameter int RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_start_addr,
  input  logic [ADDR_W-1:0]   cfg_end_addr,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [DELAY_W-1:0]  cfg_delay,
  input  logic [ADDR_W-1:0]   cfg_b_offset,
`ifdef DDS_SEQ_LOOP_EN
  input  logic [LOOP_W-1:0]   cfg_loops,
`endif
  input  logic                start,
  input  logic                stop,
  output logic                ena,
  output logic [ADDR_W-1:0]   addra,
  output logic [ADDR_W-1:0]   addrb,
  output logic                sample_valid,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_DELAY = DELAY;
  localparam logic [1:0] S_RUN   = RUN;

  logic [1:0]          state;
  logic [ADDR_W-1:0]   start_q, end_q, off_q;
  logic [PERIOD_W-1:0] period_q, pcnt, p_m1;
  logic [DELAY_W-1:0]  delay_q, dcnt;
  logic [RD_LAT:0]     sv_sr;

  logic [ADDR_W-1:0]   e_start, e_end, e_off;
  logic [DELAY_W-1:0]  e_delay;
  logic idle, we_ok, bad, go, rej;
  logic in_dly, in_run, dly_hit, hold_done;
  logic a_wrap, b_wrap, last_pass, fin;
  logic step, load, upd;

  assign idle  = (state == S_IDLE);
  assign we_ok = cfg_we && idle;

  // A start in the same cycle as a config write sees the new values.
  assign e_start = we_ok ? cfg_start_addr : start_q;
  assign e_end   = we_ok ? cfg_end_addr   : end_q;
  assign e_off   = we_ok ? cfg_b_offset   : off_q;
  assign e_delay = we_ok ? cfg_delay      : delay_q;

  assign bad = (e_end < e_start) || (e_off > e_end - e_start);
  assign go  = idle && start && !stop && !bad;
  assign rej = idle && start && !stop && bad;

  assign p_m1 = PERIOD_W'(period_eff(PERIOD_W_D'(period_q))) - PERIOD_W'(1);

  assign in_dly    = (state == S_DELAY) && !stop;
  assign in_run    = (state == S_RUN) && !stop;
  assign dly_hit   = (dcnt >= delay_q - DELAY_W'(1));
  assign hold_done = (pcnt >= p_m1);

`ifdef DDS_SEQ_LOOP_EN
  logic [LOOP_W-1:0] loops_q, lcnt;
  assign last_pass = (lcnt >= loops_q);
`else
  assign last_pass = 1'b1;
`endif

  assign fin  = in_run && hold_done && a_wrap && last_pass;
  assign step = in_run && hold_done && !fin;
  assign load = (go && (e_delay == '0)) || (in_dly && dly_hit);
  assign upd  = load || step;

  assign ena          = (state == S_RUN);
  assign busy         = !idle;
  assign sample_valid = sv_sr[RD_LAT];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      start_q  <= '0;
      end_q    <= '0;
      off_q    <= '0;
      period_q <= '0;
      delay_q  <= '0;
      pcnt     <= '0;
      dcnt     <= '0;
      sv_sr    <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
`ifdef DDS_SEQ_LOOP_EN
      loops_q  <= '0;
      lcnt     <= '0;
`endif
    end else begin
      err   <= (cfg_we && !idle) || rej;
      done  <= fin;
      sv_sr <= stop ? '0 : {sv_sr[RD_LAT-1:0], upd};
      if (we_ok) begin
        start_q  <= cfg_start_addr;
        end_q    <= cfg_end_addr;
        off_q    <= cfg_b_offset;
        period_q <= cfg_period;
        delay_q  <= cfg_delay;
`ifdef DDS_SEQ_LOOP_EN
        loops_q  <= cfg_loops;
`endif
      end
      unique case (1'b1)
        stop: state <= S_IDLE;
        go: begin
          state <= (e_delay == '0) ? S_RUN : S_DELAY;
          dcnt  <= '0;
          pcnt  <= '0;
`ifdef DDS_SEQ_LOOP_EN
          lcnt  <= '0;
`endif
        end
        in_dly: begin
          if (dly_hit) begin
            state <= S_RUN;
            pcnt  <= '0;
          end else begin
            dcnt <= dcnt + DELAY_W'(1);
          end
        end
        in_run: begin
          if (hold_done) begin
            pcnt <= '0;
            if (a_wrap && last_pass) state <= S_IDLE;
`ifdef DDS_SEQ_LOOP_EN
            else if (a_wrap) lcnt <= lcnt + LOOP_W'(1);
`endif
          end else begin
            pcnt <= pcnt + PERIOD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  dds_seq_addr_gen #(.ADDR_W(ADDR_W)) u_gen_a (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .load      (load),
    .load_addr (e_start),
    .win_start (start_q),
    .win_end   (end_q),
    .addr      (addra),
    .wrap      (a_wrap)
  );

  dds_seq_addr_gen #(.ADDR_W(ADDR_W)) u_gen_b (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .load      (load),
    .load_addr (e_start + e_off),
    .win_start (start_q),
    .win_end   (end_q),
    .addr      (addrb),
    .wrap      (b_wrap)
  );

  logic unused_b_wrap;
  assign unused_b_wrap = b_wrap;

endmodule

// File: tb/tb_dds_playback_sequencer.sv
// tb_dds_playback_sequencer: directed and random checks of the sequencer.
// Loop tests are compiled in with DDS_SEQ_LOOP_EN.
module tb_dds_playback_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [16:0] cfg_start_addr = '0;
  logic [16:0] cfg_end_addr = '0;
  logic [16:0] cfg_b_offset = '0;
  logic [15:0] cfg_period = '0;
  logic [31:0] cfg_delay = '0;
`ifdef DDS_SEQ_LOOP_EN
  logic [7:0]  cfg_loops = '0;
`endif
  logic        ena, sample_valid, busy, done, err;
  logic [16:0] addra, addrb;

  int checks = 0;
  int errors = 0;
  int m_s = 0, m_e = 0, m_p = 0, m_d = 0, m_o = 0, m_l = 0;

  always #5 clk = ~clk;

  dds_playback_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_we         (cfg_we),
    .cfg_start_addr (cfg_start_addr),
    .cfg_end_addr   (cfg_end_addr),
    .cfg_period     (cfg_period),
    .cfg_delay      (cfg_delay),
    .cfg_b_offset   (cfg_b_offset),
`ifdef DDS_SEQ_LOOP_EN
    .cfg_loops      (cfg_loops),
`endif
    .start          (start),
    .stop           (stop),
    .ena            (ena),
    .addra          (addra),
    .addrb          (addrb),
    .sample_valid   (sample_valid),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int k,
                       input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d: observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic drive_cfg(input int s, e, p, d, o, l);
    cfg_start_addr = 17'(s);
    cfg_end_addr   = 17'(e);
    cfg_period     = 16'(p);
    cfg_delay      = 32'(d);
    cfg_b_offset   = 17'(o);
`ifdef DDS_SEQ_LOOP_EN
    cfg_loops      = 8'(l);
`else
    if (l != 0) $display("note: loops ignored in this build");
`endif
  endtask

  task automatic check_quiet(input string tag, input int k);
    check({tag, ":busy"}, k, 32'(busy), 0);
    check({tag, ":ena"}, k, 32'(ena), 0);
    check({tag, ":done"}, k, 32'(done), 0);
    check({tag, ":sv"}, k, 32'(sample_valid), 0);
  endtask

  // Expected trace: pass list of addresses, each held P cycles, after D idle.
  task automatic play(input bit wr, input bit same,
                      input int s, e, p, d, o, l,
                      input int inj_kind, input int inj_at,
                      input int stop_at);
    int n, pe, len, r, idx, passes;
    if (wr) begin
      drive_cfg(s, e, p, d, o, l);
      m_s = s; m_e = e; m_p = p; m_d = d; m_o = o; m_l = l;
      if (!same) begin
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        check("cfg_err", -1, 32'(err), 0);
      end
    end
    n  = m_e - m_s + 1;
    pe = (m_p == 0) ? 1 : m_p;
    passes = 1;
`ifdef DDS_SEQ_LOOP_EN
    passes = m_l + 1;
`endif
    len = passes * n * pe;
    cfg_we = wr && same;
    start  = 1'b1;
    tick();
    cfg_we = 1'b0;
    start  = 1'b0;
    for (int k = 0; k <= m_d + len + 2; k++) begin
      r = k - m_d;
      if (stop_at >= 0 && k > stop_at) begin
        check_quiet("stopped", k);
        if (k >= stop_at + 3) break;
      end else begin
        check("busy", k, 32'(busy), 32'(r < len));
        check("ena", k, 32'(ena), 32'(r >= 0 && r < len));
        check("done", k, 32'(done), 32'(r == len));
        check("sv", k, 32'(sample_valid),
              32'(r >= 1 && r - 1 < len && (r - 1) % pe == 0));
        check("err", k, 32'(err), 32'(inj_kind == 1 && k == inj_at + 1));
        if (r >= 0) begin
          idx = (((r < len) ? r : len - 1) / pe) % n;
          check("addra", k, 32'(addra), 32'(m_s + idx));
          check("addrb", k, 32'(addrb), 32'(m_s + (idx + m_o) % n));
        end
      end
      if (k == stop_at) stop = 1'b1;
      if (k == inj_at && inj_kind == 1) begin
        drive_cfg(40, 30, 7, 9, 3, 1);
        cfg_we = 1'b1;
      end
      if (k == inj_at && inj_kind == 2) start = 1'b1;
      tick();
      stop   = 1'b0;
      cfg_we = 1'b0;
      start  = 1'b0;
    end
  endtask

  task automatic reject(input int s, e, o, input bit same);
    drive_cfg(s, e, 1, 0, o, 0);
    m_s = s; m_e = e; m_p = 1; m_d = 0; m_o = o; m_l = 0;
    if (!same) begin
      cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
    end
    cfg_we = same;
    start  = 1'b1;
    tick();
    cfg_we = 1'b0;
    start  = 1'b0;
    check("rej_err", 0, 32'(err), 1);
    check("rej_busy", 0, 32'(busy), 0);
    check("rej_ena", 0, 32'(ena), 0);
    tick();
    check("rej_err", 1, 32'(err), 0);
    check("rej_busy", 1, 32'(busy), 0);
  endtask

  initial begin
    int s, n, d, p, o, l, len, kind, at;
    reset = 1'b0;
    tick();
    tick();
    check("rst_ena", 0, 32'(ena), 0);
    check("rst_addra", 0, 32'(addra), 0);
    check("rst_addrb", 0, 32'(addrb), 0);
    check("rst_busy", 0, 32'(busy), 0);
    check("rst_done", 0, 32'(done), 0);
    check("rst_err", 0, 32'(err), 0);
    check("rst_sv", 0, 32'(sample_valid), 0);
    reset = 1'b1;
    tick();

    play(1, 1, 0, 3, 10, 0, 0, 0, 0, -1, -1);
    play(1, 0, 5, 9, 1, 0, 3, 0, 0, -1, -1);
    play(1, 1, 7, 7, 0, 4, 0, 0, 0, -1, -1);
    reject(5, 2, 0, 1);
    reject(3, 6, 4, 0);
    play(1, 1, 0, 3, 2, 1, 1, 0, 1, 5, -1);
    play(0, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1);
    play(1, 1, 2, 6, 3, 2, 2, 0, 2, 4, -1);
    play(1, 0, 0, 4, 2, 0, 1, 0, 0, -1, 6);
    play(1, 1, 0, 4, 2, 5, 1, 0, 0, -1, 2);
    play(1, 1, 131069, 131071, 1, 0, 2, 0, 0, -1, -1);

    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("ss_busy", 0, 32'(busy), 0);
    check("ss_err", 0, 32'(err), 0);
    tick();
    check("ss_busy", 1, 32'(busy), 0);

    drive_cfg(3, 8, 3, 0, 2, 0);
    cfg_we = 1'b1;
    start  = 1'b1;
    tick();
    cfg_we = 1'b0;
    start  = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b0;
    tick();
    check("mid_rst_ena", 0, 32'(ena), 0);
    check("mid_rst_addra", 0, 32'(addra), 0);
    check("mid_rst_addrb", 0, 32'(addrb), 0);
    check("mid_rst_busy", 0, 32'(busy), 0);
    check("mid_rst_done", 0, 32'(done), 0);
    check("mid_rst_err", 0, 32'(err), 0);
    check("mid_rst_sv", 0, 32'(sample_valid), 0);
    reset = 1'b1;
    m_s = 0; m_e = 0; m_p = 0; m_d = 0; m_o = 0; m_l = 0;
    tick();
    play(0, 0, 0, 0, 0, 0, 0, 0, 0, -1, -1);

`ifdef DDS_SEQ_LOOP_EN
    play(1, 1, 0, 1, 2, 0, 0, 2, 0, -1, -1);
`endif

    for (int it = 0; it < 20; it++) begin
      s = int'($urandom_range(0, 40));
      n = int'($urandom_range(1, 6));
      p = int'($urandom_range(0, 4));
      d = int'($urandom_range(0, 5));
      o = int'($urandom_range(0, n - 1));
      l = 0;
`ifdef DDS_SEQ_LOOP_EN
      l = int'($urandom_range(0, 2));
`endif
      len  = (l + 1) * n * ((p == 0) ? 1 : p);
      kind = int'($urandom_range(0, 2));
      at   = int'($urandom_range(0, d + len - 1));
      play(1, bit'($urandom_range(0, 1)), s, s + n - 1, p, d, o, l,
           kind, at, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
